tx_uart: RTL and testbench

- UART transmitter, 8N1 frame, LSB first. Serialises bytes from the BLE control logic onto the line toward the BLE module.
- Transmit-side counterpart of rx_uart; uses the same CYCLE_PER_BIT bit timing, so the two loop back directly.
- Has a one-byte holding register, so consecutive frames go out with no idle gap.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_timer.sv | 36 +++
 rtl/tx_uart.sv | 156 +++++++++++++++
 tb/tb_tx_uart.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for tx_uart / rx_uart
//
// Purpose : FSM state enum, payload width, line levels and the parity helper
//           shared by the transmitter and receiver.
// Ports   : none (package).
// Options : TX_PARITY_EN (in tx_uart) makes use of ST_PARITY and parity_bit().
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter for the UART FSMs
//
// Purpose : counts 0..CYCLE_PER_BIT-1 and wraps, marking bit boundaries.
// Ports   : clk, rst (async active-low), clear (hold count at 0),
//           bit_end (last cycle of a bit), bit_pre_end (cycle before the last,
//           lets callers register a pulse that lands on the last cycle).
module uart_bit_timer #(
    parameter int CYCLE_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CW = (CYCLE_PER_BIT > 1) ? $clog2(CYCLE_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLE_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CYCLE_PER_BIT - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end     = (cnt == LAST);
    assign bit_pre_end = (cnt == PRE);

endmodule

// File: rtl/tx_uart.sv
// rtl/tx_uart.sv - 8N1 UART transmitter with one-byte holding register
//
// Purpose : serialises bytes LSB first; a holding register lets the next byte
//           follow the previous stop bit with no idle gap.
// Ports   : clk, rst (async active-low),
//           in_valid_tx / in_ready_tx / data_tx  byte handshake,
//           out_serial_tx  registered serial line (idles high),
//           out_busy_tx    high while not idle,
//           out_done_tx    one-cycle pulse on the last cycle of each stop bit.
// Options : define TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd).
module tx_uart #(
    parameter int CYCLE_PER_BIT = 10,
    parameter int DATA_W        = 8,
    parameter int PARITY_ODD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_tx,
    output logic              in_ready_tx,
    input  logic [DATA_W-1:0] data_tx,
    output logic              out_serial_tx,
    output logic              out_busy_tx,
    output logic              out_done_tx
);

    import uart_pkg::*;

    if (CYCLE_PER_BIT < 2 || DATA_W != uart_pkg::DATA_W || PARITY_ODD < 0 || PARITY_ODD > 1)
    begin : g_param_check
        $error("tx_uart: unsupported parameter value");
    end

    uart_state_t       state;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] shift;
    logic              hold_full;
    logic [2:0]        bit_idx;
    logic              bit_end;
    logic              bit_pre_end;
    logic              push;
`ifdef TX_PARITY_EN
    logic              par;
`endif

    // Push needs an empty slot and pop needs a full one, so they never coincide.
    assign push        = in_valid_tx && !hold_full;
    assign in_ready_tx = !hold_full;

    uart_bit_timer #(
        .CYCLE_PER_BIT(CYCLE_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == ST_IDLE),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (push) begin
            hold_full <= 1'b1;
            hold_data <= data_tx;
        end else if (hold_full && (state == ST_IDLE || (state == ST_STOP && bit_end))) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            shift         <= '0;
            bit_idx       <= '0;
            out_serial_tx <= IDLE_LVL;
            out_busy_tx   <= 1'b0;
            out_done_tx   <= 1'b0;
`ifdef TX_PARITY_EN
            par           <= 1'b0;
`endif
        end else begin
            // Registered one cycle early so the pulse sits on the stop bit's last cycle.
            out_done_tx <= (state == ST_STOP) && bit_pre_end;
            case (state)
                ST_IDLE: begin
                    out_serial_tx <= IDLE_LVL;
                    if (hold_full) begin
                        state         <= ST_START;
                        shift         <= hold_data;
                        bit_idx       <= '0;
                        out_serial_tx <= START_LVL;
                        out_busy_tx   <= 1'b1;
`ifdef TX_PARITY_EN
                        par           <= parity_bit(hold_data, PARITY_ODD != 0);
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state         <= ST_DATA;
                        out_serial_tx <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
                            state         <= ST_PARITY;
                            out_serial_tx <= par;
`else
                            state         <= ST_STOP;
                            out_serial_tx <= STOP_LVL;
`endif
                        end else begin
                            bit_idx       <= bit_idx + 3'd1;
                            shift         <= shift >> 1;
                            out_serial_tx <= shift[1];
                        end
                    end
                end
`ifdef TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state         <= ST_STOP;
                        out_serial_tx <= STOP_LVL;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (hold_full) begin
                            // Back-to-back: next start bit follows with no idle cycle.
                            state         <= ST_START;
                            shift         <= hold_data;
                            bit_idx       <= '0;
                            out_serial_tx <= START_LVL;
`ifdef TX_PARITY_EN
                            par           <= parity_bit(hold_data, PARITY_ODD != 0);
`endif
                        end else begin
                            state         <= ST_IDLE;
                            out_busy_tx   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    out_serial_tx <= IDLE_LVL;
                    out_busy_tx   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_uart.sv
// tb/tb_tx_uart.sv - self-checking bench for tx_uart against a frame-timeline model
module tb_tx_uart;

    localparam int CPB  = 10;
    localparam int PODD = 0;
`ifdef TX_PARITY_EN
    localparam int NBITS  = 11;
    localparam bit PAR_ON = 1'b1;
`else
    localparam int NBITS  = 10;
    localparam bit PAR_ON = 1'b0;
`endif
    localparam int FLEN = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_tx = 1'b0;
    logic       in_ready_tx;
    logic [7:0] data_tx = 8'h00;
    logic       out_serial_tx;
    logic       out_busy_tx;
    logic       out_done_tx;

    tx_uart #(
        .CYCLE_PER_BIT(CPB),
        .DATA_W       (8),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_tx  (in_valid_tx),
        .in_ready_tx  (in_ready_tx),
        .data_tx      (data_tx),
        .out_serial_tx(out_serial_tx),
        .out_busy_tx  (out_busy_tx),
        .out_done_tx  (out_done_tx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n = 0;          // rising edges seen since the model was started
    int nf = 0;         // frames in the model
    int last_done = -1;
    int         f_acc  [64];
    int         f_start[64];
    logic [7:0] f_dat  [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    // Model: each accepted byte becomes a frame of FLEN cycles starting one edge
    // after acceptance, or right after the previous frame, whichever is later.
    function automatic void add_frame(input int a, input logic [7:0] d);
        int s;
        s = a + 1;
        if (nf > 0 && f_start[nf-1] + FLEN > s) s = f_start[nf-1] + FLEN;
        if (nf < 64) begin
            f_acc[nf]   = a;
            f_start[nf] = s;
            f_dat[nf]   = d;
            nf++;
        end
    endfunction

    function automatic bit m_hold(input int t);
        for (int i = 0; i < nf; i++)
            if (f_acc[i] <= t && t < f_start[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_frame(input int t);
        for (int i = 0; i < nf; i++)
            if (f_start[i] <= t && t < f_start[i] + FLEN) return i;
        return -1;
    endfunction

    function automatic logic m_line(input int t);
        int i;
        int k;
        i = m_frame(t);
        if (i < 0) return 1'b1;
        k = (t - f_start[i]) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return f_dat[i][k-1];
        if (PAR_ON && k == 9) return (^f_dat[i]) ^ (PODD != 0);
        return 1'b1;
    endfunction

    function automatic logic m_done(input int t);
        int i;
        i = m_frame(t);
        return (i >= 0) && (t - f_start[i] == FLEN - 1);
    endfunction

    // One clock: drive at the falling edge, move on the rising edge, check at the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] d, output bit acc);
        in_valid_tx = v;
        data_tx     = d;
        acc = v && !m_hold(n);
        @(posedge clk);
        n++;
        if (acc) add_frame(n, d);
        @(negedge clk);
        if (out_done_tx === 1'b1) last_done = n;
        check("line",  out_serial_tx, m_line(n));
        check("busy",  out_busy_tx,   m_frame(n) >= 0);
        check("done",  out_done_tx,   m_done(n));
        check("ready", in_ready_tx,   !m_hold(n));
    endtask

    task automatic send(input logic [7:0] d);
        bit acc;
        int g;
        acc = 1'b0;
        g = 0;
        while (!acc && g < 3 * FLEN) begin
            cycle(1'b1, d, acc);
            g++;
        end
        check("accept", acc, 1'b1);
    endtask

    task automatic idle(input int k);
        bit acc;
        for (int i = 0; i < k; i++) cycle(1'b0, 8'($urandom), acc);
    endtask

    initial begin
        bit acc;
        int t0;
        int s;
        int got;
        int guard;

        // reset state
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_line",  out_serial_tx, 1'b1);
        check("rst_ready", in_ready_tx,   1'b1);
        check("rst_busy",  out_busy_tx,   1'b0);
        check("rst_done",  out_done_tx,   1'b0);
        rst = 1'b1;
        n = 0;
        idle(3);

        // single byte: done lands FLEN edges after the handshake
        send(8'hA5);
        t0 = n;
        idle(FLEN + 5);
        check("single_done_time", last_done - t0, FLEN);

        // back-to-back with valid held high: two frames with no gap
        send(8'h00);
        t0 = n;
        send(8'hFF);
        idle(2 * FLEN + 5);
        check("b2b_done_time", last_done - t0, 2 * FLEN);

        // backpressure: three offers on consecutive cycles
        send(8'h11);
        send(8'h22);
        send(8'h33);
        idle(3 * FLEN + 5);

        // reset during data bit 3 with a byte waiting in the holding register
        send(8'h5A);
        s = n + 1;
        send(8'h77);
        while (n < s + 4 * CPB + 2) cycle(1'b0, 8'($urandom), acc);
        #1 rst = 1'b0;
        #1;
        check("midrst_line",  out_serial_tx, 1'b1);
        check("midrst_busy",  out_busy_tx,   1'b0);
        check("midrst_ready", in_ready_tx,   1'b1);
        nf = 0;
        in_valid_tx = 1'b0;
        @(posedge clk); n++;
        @(posedge clk); n++;
        @(negedge clk);
        check("midrst_hold_line", out_serial_tx, 1'b1);
        check("midrst_hold_done", out_done_tx,   1'b0);
        rst = 1'b1;
        idle(3);
        send(8'h3C);
        idle(FLEN + 5);

        // random traffic: valid and data churn every cycle, data changes while held
        got = 0;
        guard = 0;
        while (got < 16 && guard < 6000) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), acc);
            if (acc) got++;
            guard++;
        end
        check("rand_accepts", got, 16);
        idle(2 * FLEN + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
